// File: rtl/exe_mem_issue.sv
// rtl/exe_mem_issue.sv - EXE pipeline register with data-SRAM request issue and flush-orphan tracking
`timescale 1ns/1ps

module exe_mem_issue #(
    parameter int PC_W       = 32,
    parameter int MAX_ORPHAN = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ds2es_valid,
    output logic             es_allowin,
    input  logic [PC_W-1:0]  ds_pc,
    input  logic [7:0]       ds_mem_op,
    input  logic [31:0]      ds_base,
    input  logic [31:0]      ds_offset,
    input  logic [31:0]      ds_st_data,
    input  logic [31:0]      ds_alu_result,
    input  logic             ds_ex,
    input  logic             ms_allowin,
    output logic             es2ms_valid,
    output logic [39+PC_W:0] es2ms_bus,
    input  logic             ms_ex,
    input  logic             wb_ex,
    input  logic             ms_wait_pending,
    output logic             data_sram_req,
    output logic             data_sram_wr,
    output logic [1:0]       data_sram_size,
    output logic [3:0]       data_sram_wstrb,
    output logic [31:0]      data_sram_addr,
    output logic [31:0]      data_sram_wdata,
    input  logic             data_sram_addr_ok,
    input  logic             data_sram_data_ok,
    output logic             data_ok_discard
);

    localparam logic [2:0] LP_MAX = 3'(MAX_ORPHAN);

    // S_FLUSH: request was flushed before addr_ok; req must stay high until accepted
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_es_valid;
    logic [PC_W-1:0]  r_pc;
    logic [7:0]       r_mem_op;
    logic [31:0]      r_base;
    logic [31:0]      r_offset;
    logic [31:0]      r_st_data;
    logic [31:0]      r_alu_result;
    logic             r_ex;

    logic             r_req_wr;
    logic [1:0]       r_req_size;
    logic [3:0]       r_req_wstrb;
    logic [31:0]      r_req_addr;
    logic [31:0]      r_req_wdata;

    logic [1:0]       r_orphan_cnt;

    logic [31:0]      w_addr;
    logic             w_is_byte;
    logic             w_is_half;
    logic             w_is_word;
    logic             w_is_store;
    logic             w_is_mem;
    logic             w_ale;
    logic             w_need_req;
    logic             w_issue_ok;
    logic             w_own_accepted;
    logic             w_ready_go;
    logic             w_handoff;
    logic [1:0]       w_size;
    logic [3:0]       w_wstrb;
    logic [31:0]      w_wdata;
    logic [2:0]       w_inc;
    logic             w_dec;
    logic [2:0]       w_orphan_sum;

    assign w_addr     = r_base + r_offset;
    assign w_is_byte  = r_mem_op[7] | r_mem_op[6] | r_mem_op[2];
    assign w_is_half  = r_mem_op[5] | r_mem_op[4] | r_mem_op[1];
    assign w_is_word  = r_mem_op[3] | r_mem_op[0];
    assign w_is_store = |r_mem_op[2:0];
    assign w_is_mem   = |r_mem_op;
    assign w_ale      = (w_is_half & w_addr[0]) | (w_is_word & (|w_addr[1:0]));

    assign w_need_req = r_es_valid & w_is_mem & ~w_ale & ~r_ex;
    assign w_issue_ok = w_need_req & ~ms_ex & ~wb_ex & (r_orphan_cnt == 2'd0);

    always_comb begin
        w_size  = 2'd2;
        w_wstrb = 4'b1111;
        w_wdata = r_st_data;
        if (w_is_byte) begin
            w_size  = 2'd0;
            w_wstrb = 4'b0001 << w_addr[1:0];
            w_wdata = {4{r_st_data[7:0]}};
        end else if (w_is_half) begin
            w_size  = 2'd1;
            w_wstrb = w_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{r_st_data[15:0]}};
        end
        if (!w_is_store) begin
            w_wstrb = 4'b0000;
        end
    end

    assign w_own_accepted = (r_state == S_DONE) | ((r_state == S_REQ) & data_sram_addr_ok);
    assign w_ready_go     = (r_state == S_FLUSH) ? 1'b0 : (~w_need_req | w_own_accepted);

    assign es_allowin  = ~r_es_valid | (w_ready_go & ms_allowin);
    assign es2ms_valid = r_es_valid & w_ready_go;
    assign w_handoff   = es2ms_valid & ms_allowin;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_issue_ok) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (data_sram_addr_ok) begin
                    if (wb_ex || w_handoff) w_state_nxt = S_IDLE;
                    else                    w_state_nxt = S_DONE;
                end else if (wb_ex) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_DONE: begin
                if (wb_ex || w_handoff) w_state_nxt = S_IDLE;
            end
            S_FLUSH: begin
                if (data_sram_addr_ok) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_es_valid   <= 1'b0;
            r_pc         <= '0;
            r_mem_op     <= '0;
            r_base       <= '0;
            r_offset     <= '0;
            r_st_data    <= '0;
            r_alu_result <= '0;
            r_ex         <= 1'b0;
        end else begin
            if (wb_ex) begin
                r_es_valid <= 1'b0;
            end else if (es_allowin) begin
                r_es_valid <= ds2es_valid;
            end
            if (ds2es_valid && es_allowin && !wb_ex) begin
                r_pc         <= ds_pc;
                r_mem_op     <= ds_mem_op;
                r_base       <= ds_base;
                r_offset     <= ds_offset;
                r_st_data    <= ds_st_data;
                r_alu_result <= ds_alu_result;
                r_ex         <= ds_ex;
            end
        end
    end

    // Request fields are snapshotted so they stay stable even after a flush frees the EXE slot
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_wr    <= 1'b0;
            r_req_size  <= '0;
            r_req_wstrb <= '0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
        end else if ((r_state == S_IDLE) && w_issue_ok) begin
            r_req_wr    <= w_is_store;
            r_req_size  <= w_size;
            r_req_wstrb <= w_wstrb;
            r_req_addr  <= w_addr;
            r_req_wdata <= w_wdata;
        end
    end

    assign w_inc = {2'b00, wb_ex & ms_wait_pending}
                 + {2'b00, wb_ex & w_own_accepted}
                 + {2'b00, (r_state == S_FLUSH) & data_sram_addr_ok};
    assign w_dec = data_sram_data_ok & (r_orphan_cnt != 2'd0);
    assign w_orphan_sum = {1'b0, r_orphan_cnt} + w_inc - {2'b00, w_dec};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_orphan_cnt <= 2'd0;
        end else if (w_orphan_sum > LP_MAX) begin
            r_orphan_cnt <= LP_MAX[1:0];
        end else begin
            r_orphan_cnt <= w_orphan_sum[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (w_orphan_sum <= LP_MAX) else $error("orphan counter overflow");
        end
    end

    assign data_ok_discard = data_sram_data_ok & (r_orphan_cnt != 2'd0);

    assign data_sram_req   = (r_state == S_REQ) | (r_state == S_FLUSH);
    assign data_sram_wr    = r_req_wr;
    assign data_sram_size  = r_req_size;
    assign data_sram_wstrb = r_req_wstrb;
    assign data_sram_addr  = r_req_addr;
    assign data_sram_wdata = r_req_wdata;

    assign es2ms_bus = {w_need_req, r_mem_op[7:3], w_ale,
                        (w_is_mem ? w_addr : r_alu_result),
                        r_pc, r_ex | w_ale};

endmodule

// File: tb/tb_exe_mem_issue.sv
// tb/tb_exe_mem_issue.sv - scoreboard bench for exe_mem_issue
`timescale 1ns/1ps

module tb_exe_mem_issue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ds2es_valid = 1'b0;
    logic        es_allowin;
    logic [31:0] ds_pc = '0;
    logic [7:0]  ds_mem_op = '0;
    logic [31:0] ds_base = '0;
    logic [31:0] ds_offset = '0;
    logic [31:0] ds_st_data = '0;
    logic [31:0] ds_alu_result = '0;
    logic        ds_ex = 1'b0;
    logic        ms_allowin = 1'b1;
    logic        es2ms_valid;
    logic [71:0] es2ms_bus;
    logic        ms_ex = 1'b0;
    logic        wb_ex = 1'b0;
    logic        ms_wait_pending = 1'b0;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok = 1'b0;
    logic        data_sram_data_ok = 1'b0;
    logic        data_ok_discard;

    int checks = 0;
    int failures = 0;

    logic [71:0] bus_q[$];
    logic [70:0] req_q[$];
    logic        disc_q[$];

    logic        prev_held = 1'b0;
    logic [31:0] prev_addr = '0;

    localparam logic [7:0] OP_LD_B = 8'b1000_0000;
    localparam logic [7:0] OP_LD_H = 8'b0010_0000;
    localparam logic [7:0] OP_LD_W = 8'b0000_1000;
    localparam logic [7:0] OP_ST_B = 8'b0000_0100;
    localparam logic [7:0] OP_ST_H = 8'b0000_0010;
    localparam logic [7:0] OP_ST_W = 8'b0000_0001;

    exe_mem_issue #(.PC_W(32), .MAX_ORPHAN(3)) dut (
        .clk(clk), .reset(reset),
        .ds2es_valid(ds2es_valid), .es_allowin(es_allowin),
        .ds_pc(ds_pc), .ds_mem_op(ds_mem_op), .ds_base(ds_base), .ds_offset(ds_offset),
        .ds_st_data(ds_st_data), .ds_alu_result(ds_alu_result), .ds_ex(ds_ex),
        .ms_allowin(ms_allowin), .es2ms_valid(es2ms_valid), .es2ms_bus(es2ms_bus),
        .ms_ex(ms_ex), .wb_ex(wb_ex), .ms_wait_pending(ms_wait_pending),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_ok_discard(data_ok_discard)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] mk_bus(input logic w, input logic [4:0] z, input logic a,
                                           input logic [31:0] badv, input logic [31:0] pc,
                                           input logic ex);
        return {w, z, a, badv, pc, ex};
    endfunction

    function automatic logic [70:0] mk_req(input logic wr, input logic [1:0] sz, input logic [3:0] st,
                                           input logic [31:0] ad, input logic [31:0] wd);
        return {wr, sz, st, ad, wd};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (es2ms_valid && ms_allowin) begin
                if (bus_q.size() == 0) chk("unexpected_handoff", {71'b0, es2ms_valid}, 72'd0);
                else chk("es2ms_bus", es2ms_bus, bus_q.pop_front());
            end
            if (data_sram_req) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", {71'b0, data_sram_req}, 72'd0);
                end else if (data_sram_addr_ok) begin
                    chk("sram_req", {1'b0, data_sram_wr, data_sram_size, data_sram_wstrb,
                                     data_sram_addr, data_sram_wdata}, {1'b0, req_q.pop_front()});
                end
                if (prev_held) chk("req_addr_stable", {40'b0, data_sram_addr}, {40'b0, prev_addr});
            end
            if (data_sram_data_ok) begin
                if (disc_q.size() == 0) chk("unexpected_data_ok", {71'b0, data_sram_data_ok}, 72'd0);
                else chk("data_ok_discard", {71'b0, data_ok_discard}, {71'b0, disc_q.pop_front()});
            end
            prev_held = data_sram_req & ~data_sram_addr_ok;
            prev_addr = data_sram_addr;
        end else begin
            prev_held = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] op, input logic [31:0] pc, input logic [31:0] base,
                        input logic [31:0] off, input logic [31:0] sdata, input logic [31:0] alu,
                        input logic ex);
        int n;
        ds_mem_op = op; ds_pc = pc; ds_base = base; ds_offset = off;
        ds_st_data = sdata; ds_alu_result = alu; ds_ex = ex;
        ds2es_valid = 1'b1;
        n = 0;
        while (!es_allowin && n < 50) begin
            cyc(1);
            n++;
        end
        if (n >= 50) chk("send_timeout", {71'b0, es_allowin}, 72'd1);
        cyc(1);
        ds2es_valid = 1'b0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!data_sram_req && n < 50) begin
            cyc(1);
            n++;
        end
        if (n >= 50) chk("req_timeout", {71'b0, data_sram_req}, 72'd1);
    endtask

    task automatic accept_req(input int delay);
        wait_req();
        cyc(delay);
        data_sram_addr_ok = 1'b1;
        cyc(1);
        data_sram_addr_ok = 1'b0;
    endtask

    task automatic pulse_data_ok(input logic exp_discard);
        disc_q.push_back(exp_discard);
        data_sram_data_ok = 1'b1;
        cyc(1);
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(2);
        @(negedge clk);
        chk("rst_allowin", {71'b0, es_allowin}, 72'd1);
        chk("rst_es2ms_valid", {71'b0, es2ms_valid}, 72'd0);
        chk("rst_bus", es2ms_bus, 72'd0);
        chk("rst_req", {71'b0, data_sram_req}, 72'd0);
        chk("rst_sram_fields", {1'b0, data_sram_wr, data_sram_size, data_sram_wstrb,
                                data_sram_addr, data_sram_wdata, data_ok_discard}, 72'd0);
        cyc(1);
        reset = 1'b0;
        cyc(1);

        // ld_w 0x1004, immediate addr_ok
        req_q.push_back(mk_req(1'b0, 2'd2, 4'b0000, 32'h0000_1004, 32'h0));
        bus_q.push_back(mk_bus(1'b1, 5'b00001, 1'b0, 32'h0000_1004, 32'h0000_0100, 1'b0));
        send(OP_LD_W, 32'h100, 32'h1000, 32'h4, 32'h0, 32'h0, 1'b0);
        accept_req(0);
        cyc(2);
        pulse_data_ok(1'b0);

        // st_b 0x2003 via negative offset, one-cycle addr_ok delay
        req_q.push_back(mk_req(1'b1, 2'd0, 4'b1000, 32'h0000_2003, 32'h7878_7878));
        bus_q.push_back(mk_bus(1'b1, 5'b00000, 1'b0, 32'h0000_2003, 32'h0000_0200, 1'b0));
        send(OP_ST_B, 32'h200, 32'h2010, 32'hFFFF_FFF3, 32'h1234_5678, 32'h0, 1'b0);
        accept_req(1);
        pulse_data_ok(1'b0);

        // misaligned ld_h, non-memory op, store with upstream exception: no request
        bus_q.push_back(mk_bus(1'b0, 5'b00100, 1'b1, 32'h0000_3001, 32'h0000_0300, 1'b1));
        send(OP_LD_H, 32'h300, 32'h3000, 32'h1, 32'h0, 32'h0, 1'b0);
        bus_q.push_back(mk_bus(1'b0, 5'b00000, 1'b0, 32'hDEAD_BEEF, 32'h0000_0304, 1'b0));
        send(8'h00, 32'h304, 32'h3000, 32'h1, 32'h0, 32'hDEAD_BEEF, 1'b0);
        bus_q.push_back(mk_bus(1'b0, 5'b00000, 1'b0, 32'h0000_8010, 32'h0000_0308, 1'b1));
        send(OP_ST_W, 32'h308, 32'h8000, 32'h10, 32'h5555_AAAA, 32'h0, 1'b1);
        cyc(2);

        // flush while addr_ok withheld: req held, no handoff, one orphan
        req_q.push_back(mk_req(1'b0, 2'd2, 4'b0000, 32'h0000_4000, 32'h0));
        send(OP_LD_W, 32'h400, 32'h4000, 32'h0, 32'h0, 32'h0, 1'b0);
        wait_req();
        cyc(1);
        wb_ex = 1'b1;
        cyc(1);
        wb_ex = 1'b0;
        cyc(1);
        data_sram_addr_ok = 1'b1;
        cyc(1);
        data_sram_addr_ok = 1'b0;
        cyc(2);
        pulse_data_ok(1'b1);
        pulse_data_ok(1'b0);

        // two orphans: MEM pending plus own accepted request
        ms_allowin = 1'b0;
        req_q.push_back(mk_req(1'b0, 2'd2, 4'b0000, 32'h0000_5000, 32'h0));
        send(OP_LD_W, 32'h500, 32'h5000, 32'h0, 32'h0, 32'h0, 1'b0);
        accept_req(0);
        wb_ex = 1'b1;
        ms_wait_pending = 1'b1;
        cyc(1);
        wb_ex = 1'b0;
        ms_wait_pending = 1'b0;
        ms_allowin = 1'b1;
        req_q.push_back(mk_req(1'b0, 2'd0, 4'b0000, 32'h0000_6002, 32'h0));
        bus_q.push_back(mk_bus(1'b1, 5'b10000, 1'b0, 32'h0000_6002, 32'h0000_0600, 1'b0));
        send(OP_LD_B, 32'h600, 32'h6000, 32'h2, 32'h0, 32'h0, 1'b0);
        cyc(2);
        @(negedge clk);
        chk("stall_req_cnt2", {71'b0, data_sram_req}, 72'd0);
        cyc(1);
        pulse_data_ok(1'b1);
        @(negedge clk);
        chk("stall_req_cnt1", {71'b0, data_sram_req}, 72'd0);
        cyc(1);
        pulse_data_ok(1'b1);
        accept_req(0);
        cyc(1);
        pulse_data_ok(1'b0);

        // MEM back-pressure after addr_ok: hold DONE, single request
        ms_allowin = 1'b0;
        req_q.push_back(mk_req(1'b1, 2'd1, 4'b1100, 32'h0000_7002, 32'hBABE_BABE));
        bus_q.push_back(mk_bus(1'b1, 5'b00000, 1'b0, 32'h0000_7002, 32'h0000_0700, 1'b0));
        send(OP_ST_H, 32'h700, 32'h7000, 32'h2, 32'hCAFE_BABE, 32'h0, 1'b0);
        accept_req(0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("done_no_req", {71'b0, data_sram_req}, 72'd0);
            chk("done_es2ms_valid", {71'b0, es2ms_valid}, 72'd1);
            cyc(1);
        end
        ms_allowin = 1'b1;
        cyc(1);
        @(negedge clk);
        chk("after_handoff_valid", {71'b0, es2ms_valid}, 72'd0);
        cyc(1);
        pulse_data_ok(1'b0);

        // reset in the middle of a pending request
        req_q.push_back(mk_req(1'b0, 2'd2, 4'b0000, 32'h0000_9000, 32'h0));
        send(OP_LD_W, 32'h900, 32'h9000, 32'h0, 32'h0, 32'h0, 1'b0);
        wait_req();
        reset = 1'b1;
        cyc(1);
        req_q.delete();
        @(negedge clk);
        chk("midrst_allowin", {71'b0, es_allowin}, 72'd1);
        chk("midrst_req", {71'b0, data_sram_req}, 72'd0);
        chk("midrst_es2ms_valid", {71'b0, es2ms_valid}, 72'd0);
        chk("midrst_bus", es2ms_bus, 72'd0);
        cyc(1);
        reset = 1'b0;
        cyc(3);

        chk("bus_q_empty", 72'(bus_q.size()), 72'd0);
        chk("req_q_empty", 72'(req_q.size()), 72'd0);
        chk("disc_q_empty", 72'(disc_q.size()), 72'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_mem_issue.md
Name: exe_mem_issue

Overview:
- EXE-stage pipeline register plus data-SRAM request issuer. It sits between the decode stage and the memory stage.
- It forms the effective address, checks alignment, and generates size/wstrb/wdata. It issues the data-SRAM request and completes the req/addr_ok handshake.
- It hands the memory stage a bus that says whether a data_ok response must be waited for.
- It tracks responses orphaned by a flush and discards them, so a later load never consumes stale data.

Parameters:
- PC_W, 32, program-counter width.
- MAX_ORPHAN, 3, maximum count of outstanding responses awaiting discard (2-bit counter).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- ds2es_valid  in  1  decode has an instruction
- es_allowin  out  1  EXE can accept
- ds_pc  in  32  instruction PC
- ds_mem_op  in  8  one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w}; all zero means not a memory op
- ds_base  in  32  rj value
- ds_offset  in  32  sign-extended immediate
- ds_st_data  in  32  rd value for stores
- ds_alu_result  in  32  result for non-memory ops
- ds_ex  in  1  exception already attached upstream
- ms_allowin  in  1  MEM can accept
- es2ms_valid  out  1  bus valid
- es2ms_bus  out  72  {wait_data_ok, ld_zip[4:0], ale, badv_or_result[31:0], pc[31:0], ex}
- ms_ex  in  1  MEM holds an excepting instruction
- wb_ex  in  1  WB flush
- ms_wait_pending  in  1  MEM holds an accepted load/store still awaiting data_ok
- data_sram_req  out  1  request
- data_sram_wr  out  1  1 for store
- data_sram_size  out  2  0 = byte, 1 = half, 2 = word
- data_sram_wstrb  out  4  byte enables
- data_sram_addr  out  32  address
- data_sram_wdata  out  32  replicated store data
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  response
- data_ok_discard  out  1  current data_ok belongs to an orphaned request; MEM must ignore it

Behaviour:
- Reset values:
  - es_valid = 0, FSM = IDLE, orphan_cnt = 0.
  - Every output 0, except es_allowin = 1.
  - Payload registers cleared.
- Latch: on ds2es_valid & es_allowin & ~wb_ex, capture all ds_* inputs.
- es_valid update:
  - wb_ex clears es_valid.
  - Otherwise, when es_allowin, es_valid <= ds2es_valid.
- Address and alignment:
  - addr = base + offset, mod 2^32.
  - ale = (half op & addr[0]) | (word op & |addr[1:0]).
- Request condition: issue_ok = es_valid & mem_op & ~ale & ~ds_ex & ~ms_ex & ~wb_ex & (orphan_cnt == 0).
- size / wstrb / wdata:
  - Byte: size 0; wstrb = 1 << addr[1:0]; wdata = {4{data[7:0]}}.
  - Half: size 1; wstrb = addr[1] ? 1100 : 0011; wdata = {2{data[15:0]}}.
  - Word: size 2; wstrb = 1111; wdata = data.
  - Loads drive wstrb = 0.
- FSM:
  - IDLE -> REQ when issue_ok.
  - REQ: data_sram_req = 1, address/data held stable. On addr_ok go to DONE; if wb_ex is sampled in the same cycle, go to IDLE and increment orphan_cnt.
  - A request, once raised, is never withdrawn. If wb_ex arrives in REQ without addr_ok, req stays high until addr_ok; FSM then returns to IDLE and orphan_cnt increments.
  - DONE -> IDLE when es2ms handoff (es2ms_valid & ms_allowin) or wb_ex.
- data_sram_req is driven only in REQ, combinationally from state, never from issue_ok directly.
- es_ready_go:
  - 1 for non-memory, ale, or ds_ex instructions.
  - For issuing ops, 1 only in DONE, or in REQ with addr_ok.
  - Forced 0 while a flush-induced wait-for-addr_ok is in progress.
- Valid/allowin: es_allowin = ~es_valid | es_ready_go & ms_allowin; es2ms_valid = es_valid & es_ready_go.
- Bus fields:
  - wait_data_ok = 1 only if a request was actually issued.
  - ex = ds_ex | ale.
  - badv_or_result = addr for memory ops, else ds_alu_result.
- Orphan counter:
  - On wb_ex, orphan_cnt += ms_wait_pending + (own request already accepted but not yet handed off: DONE, or REQ with addr_ok).
  - Each data_sram_data_ok while orphan_cnt != 0 asserts data_ok_discard combinationally and decrements.
  - Simultaneous increment and decrement net out.
  - Saturates at MAX_ORPHAN; an assertion is raised if exceeded.
- ms_ex suppresses new issue only. A request already in REQ completes normally.
- Reset mid-transaction returns everything to reset values on the next edge; the external SRAM model is reset concurrently.

Test Plan:
- ld_w, base 0x1000, offset 4, addr_ok on first cycle -> req 1 cycle, addr 0x1004, size 2, wstrb 0, es2ms wait_data_ok = 1 next cycle.
- st_b, addr 0x2003, data 0x12345678 -> wstrb 1000, wdata 0x78787878, size 0, wr 1.
- ld_h at 0x3001 -> no req, es2ms ex = 1, ale = 1, badv 0x3001, wait_data_ok = 0, zero-cycle pass.
- addr_ok withheld 3 cycles, wb_ex in the 2nd cycle -> req held with stable addr until addr_ok, es2ms_valid never asserts, orphan_cnt = 1; next data_ok shows data_ok_discard = 1, cnt returns to 0.
- wb_ex with ms_wait_pending = 1 and own request accepted -> orphan_cnt = 2; following load stalls in IDLE until two data_ok are discarded, then issues.
- ms_allowin low 4 cycles after addr_ok -> FSM holds DONE, single request only, handoff when ms_allowin rises.
